// File: rtl/sram_access_pkg.sv
// Shared types and helpers for the SRAM access sequencer.
//   state_e     - sequencer states
//   strobes_t   - active-low SRAM strobe bundle {ce, oe, we, ub, lb}
//   StrobesIdle - all strobes deasserted
//   clamp_wait  - forces wait-state parameters to at least one cycle
package sram_access_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdAcc,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StDone
  } state_e;

  typedef struct packed {
    logic ce;
    logic oe;
    logic we;
    logic ub;
    logic lb;
  } strobes_t;

  localparam strobes_t StrobesIdle = '{ce: 1'b1, oe: 1'b1, we: 1'b1, ub: 1'b1, lb: 1'b1};

  function automatic int clamp_wait(input int w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sram_access_ctrl_if.sv
// Bundle between the CPU memory port, the sequencer and the SRAM pad side.
//   CPU side : Req, Wr, Be, Addr_in, Data_wr -> ; <- Ready, Done, Data_rd
//   SRAM side: CE, OE, WE, UB, LB, ADDR, Data_to_SRAM, Drive_en -> ; <- Data_from_SRAM
// master: the environment (CPU plus SRAM/pad buffer); slave: the sequencer.
interface sram_access_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              Req;
  logic              Wr;
  logic [1:0]        Be;
  logic [ADDR_W-1:0] Addr_in;
  logic [DATA_W-1:0] Data_wr;
  logic              Ready;
  logic              Done;
  logic [DATA_W-1:0] Data_rd;
  logic              CE;
  logic              OE;
  logic              WE;
  logic              UB;
  logic              LB;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Data_to_SRAM;
  logic [DATA_W-1:0] Data_from_SRAM;
  logic              Drive_en;

  modport master (
    output Req, Wr, Be, Addr_in, Data_wr, Data_from_SRAM,
    input  Ready, Done, Data_rd, CE, OE, WE, UB, LB, ADDR, Data_to_SRAM, Drive_en
  );

  modport slave (
    input  Req, Wr, Be, Addr_in, Data_wr, Data_from_SRAM,
    output Ready, Done, Data_rd, CE, OE, WE, UB, LB, ADDR, Data_to_SRAM, Drive_en
  );
endinterface

// File: rtl/sram_wait_timer.sv
// Loadable down-counter used to time strobe pulse widths.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   load_i        - load load_val_i (has priority over dec_i)
//   dec_i         - decrement, saturating at zero
//   zero_o        - count is zero
module sram_wait_timer #(
  parameter int Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Sequencer between the CPU memory port and an external async SRAM. A single-cycle
// Req/Ready accept is turned into timed CE/OE/WE/UB/LB strobe sequences; completion
// is signalled by a one-cycle Done pulse. Every output comes straight from a register.
//   Clk   - system clock, rising edge
//   Reset - asynchronous active-low reset
//   bus   - CPU request/response plus SRAM strobes/data (slave side)
module sram_access_ctrl
  import sram_access_pkg::*;
#(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2,
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16
) (
  input logic               Clk,
  input logic               Reset,
  sram_access_ctrl_if.slave bus
);

  localparam int RdWait  = clamp_wait(READ_WAIT);
  localparam int WrWait  = clamp_wait(WRITE_WAIT);
  localparam int MaxWait = (RdWait > WrWait) ? RdWait : WrWait;
  localparam int CntW    = $clog2(MaxWait) + 1;
  // Timer holds cycles remaining after the current one, hence the -1.
  localparam logic [CntW-1:0] RdLoad = CntW'(RdWait - 1);
  localparam logic [CntW-1:0] WrLoad = CntW'(WrWait - 1);

  state_e            state_q;
  strobes_t          strb_q;
  logic              drive_q;
  logic              ready_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic            accept;
  logic            tmr_load;
  logic            tmr_dec;
  logic            tmr_zero;
  logic [CntW-1:0] tmr_val;

  // ready_q is only ever set while idle, so it alone qualifies the accept.
  assign accept   = bus.Req && ready_q && (state_q == StIdle);
  assign tmr_load = (accept && !bus.Wr) || (state_q == StWrSetup);
  assign tmr_val  = (state_q == StWrSetup) ? WrLoad : RdLoad;
  assign tmr_dec  = (state_q == StRdAcc) || (state_q == StWrPulse);

  sram_wait_timer #(
    .Width (CntW)
  ) u_timer (
    .clk_i      (Clk),
    .rst_ni     (Reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      strb_q  <= StrobesIdle;
      drive_q <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q <= 1'b0;
            addr_q  <= bus.Addr_in;
            if (bus.Wr) begin
              wdata_q <= bus.Data_wr;
              drive_q <= 1'b1;
              strb_q  <= '{ce: 1'b0, oe: 1'b1, we: 1'b1, ub: ~bus.Be[1], lb: ~bus.Be[0]};
              state_q <= StWrSetup;
            end else begin
              strb_q  <= '{ce: 1'b0, oe: 1'b0, we: 1'b1, ub: ~bus.Be[1], lb: ~bus.Be[0]};
              state_q <= StRdAcc;
            end
          end
        end
        StRdAcc: begin
          if (tmr_zero) begin
            rdata_q <= bus.Data_from_SRAM;
            strb_q  <= StrobesIdle;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StWrSetup: begin
          strb_q.we <= 1'b0;
          state_q   <= StWrPulse;
        end
        StWrPulse: begin
          if (tmr_zero) begin
            strb_q.we <= 1'b1;
            state_q   <= StWrHold;
          end
        end
        StWrHold: begin
          strb_q  <= StrobesIdle;
          drive_q <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          strb_q  <= StrobesIdle;
          drive_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // The pad buffer and the SRAM must never drive the data bus together.
  assert property (@(posedge Clk) disable iff (!Reset) !(drive_q && !strb_q.oe));

  assign bus.Ready        = ready_q;
  assign bus.Done         = done_q;
  assign bus.Data_rd      = rdata_q;
  assign bus.CE           = strb_q.ce;
  assign bus.OE           = strb_q.oe;
  assign bus.WE           = strb_q.we;
  assign bus.UB           = strb_q.ub;
  assign bus.LB           = strb_q.lb;
  assign bus.ADDR         = addr_q;
  assign bus.Data_to_SRAM = wdata_q;
  assign bus.Drive_en     = drive_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: a READ_WAIT=WRITE_WAIT=2 instance driven from a vector
// table plus reset/back-to-back sequences, and a READ_WAIT=0 instance for clamping.
module tb_sram_access_ctrl;

  localparam int RW = 2;
  localparam int WW = 2;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  sram_access_ctrl_if #(.ADDR_W(20), .DATA_W(16)) bus1 ();
  sram_access_ctrl_if #(.ADDR_W(20), .DATA_W(16)) bus2 ();

  sram_access_ctrl #(
    .READ_WAIT(RW), .WRITE_WAIT(WW), .ADDR_W(20), .DATA_W(16)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus1)
  );

  sram_access_ctrl #(
    .READ_WAIT(0), .WRITE_WAIT(0), .ADDR_W(20), .DATA_W(16)
  ) dut_clamp (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus2)
  );

  // SRAM model: preloaded while in reset, written on edges where CE and WE are low.
  logic [15:0] mem [0:1048575];
  assign bus1.Data_from_SRAM = mem[bus1.ADDR];
  assign bus2.Data_from_SRAM = mem[bus2.ADDR];

  always @(posedge Clk) begin
    if (!Reset) begin
      mem[20'h00012] <= 16'hBEEF;
      mem[20'h00020] <= 16'hCAFE;
      mem[20'h00040] <= 16'h1122;
      mem[20'h00007] <= 16'h7777;
      mem[20'h0FFFF] <= 16'h0000;
    end else if (!bus1.CE && !bus1.WE && bus1.Drive_en) begin
      if (!bus1.UB) mem[bus1.ADDR][15:8] <= bus1.Data_to_SRAM[15:8];
      if (!bus1.LB) mem[bus1.ADDR][7:0] <= bus1.Data_to_SRAM[7:0];
    end
  end

  // {CE, OE, WE, UB, LB, Drive_en, Done, Ready}
  logic [7:0] st1, st2;
  assign st1 = {bus1.CE, bus1.OE, bus1.WE, bus1.UB, bus1.LB, bus1.Drive_en, bus1.Done, bus1.Ready};
  assign st2 = {bus2.CE, bus2.OE, bus2.WE, bus2.UB, bus2.LB, bus2.Drive_en, bus2.Done, bus2.Ready};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_st(input logic ce, oe, we, ub, lb, de, dn, rdy);
    return {ce, oe, we, ub, lb, de, dn, rdy};
  endfunction

  task automatic wait_ready1(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (bus1.Ready) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, " ready"}, 32'(ok), 32'(1'b1));
  endtask

  // One access on the main instance; inputs are scrambled after the accept edge.
  task automatic access1(input logic wr, input logic [1:0] be, input logic [19:0] addr,
                         input logic [15:0] wd, input logic [15:0] exp_rd, input string tag);
    bit         ok;
    int         n;
    logic [7:0] e;
    logic       ub, lb;
    wait_ready1(tag, ok);
    if (!ok) return;
    bus1.Req = 1'b1; bus1.Wr = wr; bus1.Be = be; bus1.Addr_in = addr; bus1.Data_wr = wd;
    ub = ~be[1];
    lb = ~be[0];
    n  = wr ? WW + 4 : RW + 2;
    for (int c = 1; c <= n; c++) begin
      @(negedge Clk);
      if (c == 1) begin
        bus1.Req = 1'b0; bus1.Wr = ~wr; bus1.Be = ~be; bus1.Addr_in = ~addr; bus1.Data_wr = ~wd;
      end
      if (!wr) begin
        if (c <= RW)          e = exp_st(0, 0, 1, ub, lb, 0, 0, 0);
        else if (c == RW + 1) e = exp_st(1, 1, 1, 1, 1, 0, 1, 0);
        else                  e = exp_st(1, 1, 1, 1, 1, 0, 0, 1);
      end else begin
        if (c == 1)           e = exp_st(0, 1, 1, ub, lb, 1, 0, 0);
        else if (c <= WW + 1) e = exp_st(0, 1, 0, ub, lb, 1, 0, 0);
        else if (c == WW + 2) e = exp_st(0, 1, 1, ub, lb, 1, 0, 0);
        else if (c == WW + 3) e = exp_st(1, 1, 1, 1, 1, 0, 1, 0);
        else                  e = exp_st(1, 1, 1, 1, 1, 0, 0, 1);
      end
      check($sformatf("%s c%0d strobes", tag, c), 32'(st1), 32'(e));
      if (c == 1) begin
        check({tag, " addr"}, 32'(bus1.ADDR), 32'(addr));
        if (wr) check({tag, " wdata"}, 32'(bus1.Data_to_SRAM), 32'(wd));
      end
      if (c == n - 1) check({tag, " data_rd"}, 32'(bus1.Data_rd), 32'(exp_rd));
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  be;
    logic [19:0] addr;
    logic [15:0] wd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int dones;
    bit seen_done;

    vecs[0] = '{wr: 1'b0, be: 2'b11, addr: 20'h00012, wd: 16'h0000, exp_rd: 16'hBEEF};
    vecs[1] = '{wr: 1'b1, be: 2'b11, addr: 20'h0FFFF, wd: 16'h1234, exp_rd: 16'hBEEF};
    vecs[2] = '{wr: 1'b0, be: 2'b11, addr: 20'h0FFFF, wd: 16'h0000, exp_rd: 16'h1234};
    vecs[3] = '{wr: 1'b1, be: 2'b10, addr: 20'h00040, wd: 16'hAB00, exp_rd: 16'h1234};
    vecs[4] = '{wr: 1'b0, be: 2'b11, addr: 20'h00040, wd: 16'h0000, exp_rd: 16'hAB22};
    vecs[5] = '{wr: 1'b1, be: 2'b00, addr: 20'h00020, wd: 16'hFFFF, exp_rd: 16'hAB22};
    vecs[6] = '{wr: 1'b0, be: 2'b01, addr: 20'h00020, wd: 16'h0000, exp_rd: 16'hCAFE};

    bus1.Req = 1'b0; bus1.Wr = 1'b0; bus1.Be = 2'b00; bus1.Addr_in = '0; bus1.Data_wr = '0;
    bus2.Req = 1'b0; bus2.Wr = 1'b0; bus2.Be = 2'b00; bus2.Addr_in = '0; bus2.Data_wr = '0;

    // Power-on reset
    #1 Reset = 1'b0;
    #1;
    check("reset strobes", 32'(st1), 32'(exp_st(1, 1, 1, 1, 1, 0, 0, 0)));
    check("reset data_rd", 32'(bus1.Data_rd), 32'h0);
    check("reset addr", 32'(bus1.ADDR), 32'h0);
    check("reset wdata", 32'(bus1.Data_to_SRAM), 32'h0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    #1 check("release ready low", 32'(bus1.Ready), 32'h0);
    @(negedge Clk);
    check("first edge ready", 32'(st1), 32'(exp_st(1, 1, 1, 1, 1, 0, 0, 1)));

    // Reset in the middle of a write pulse
    wait_ready1("rstwr", ok);
    bus1.Req = 1'b1; bus1.Wr = 1'b1; bus1.Be = 2'b11; bus1.Addr_in = 20'h00100;
    bus1.Data_wr = 16'h5555;
    @(negedge Clk);
    bus1.Req = 1'b0;
    @(negedge Clk);
    check("rstwr pulse", 32'(st1), 32'(exp_st(0, 1, 0, 0, 0, 1, 0, 0)));
    #2 Reset = 1'b0;
    #1 check("rstwr abort", 32'(st1), 32'(exp_st(1, 1, 1, 1, 1, 0, 0, 0)));
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (bus1.Done) seen_done = 1'b1;
    end
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (bus1.Done) seen_done = 1'b1;
    end
    check("rstwr no done", 32'(seen_done), 32'h0);
    check("rstwr idle ready", 32'(st1), 32'(exp_st(1, 1, 1, 1, 1, 0, 0, 1)));

    // Table-driven accesses
    for (int i = 0; i < 7; i++) begin
      access1(vecs[i].wr, vecs[i].be, vecs[i].addr, vecs[i].wd, vecs[i].exp_rd,
              $sformatf("vec%0d", i));
    end
    check("mem ffff", 32'(mem[20'h0FFFF]), 32'h1234);
    check("mem 0040 byte", 32'(mem[20'h00040]), 32'hAB22);
    check("mem 0020 be00", 32'(mem[20'h00020]), 32'hCAFE);

    // Back-to-back reads with Req held high
    wait_ready1("b2b", ok);
    bus1.Req = 1'b1; bus1.Wr = 1'b0; bus1.Be = 2'b11; bus1.Addr_in = 20'h00012;
    dones = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      if (c == 1) bus1.Addr_in = 20'h00020;
      if (bus1.Done) dones++;
      if (c == 2) check("b2b latched addr", 32'(bus1.ADDR), 32'h00012);
      if (c == 3) begin
        check("b2b c3 strobes", 32'(st1), 32'(exp_st(1, 1, 1, 1, 1, 0, 1, 0)));
        check("b2b first data", 32'(bus1.Data_rd), 32'hBEEF);
      end
      if (c == 4) check("b2b c4 ready", 32'(bus1.Ready), 32'h1);
      if (c == 5) begin
        check("b2b second addr", 32'(bus1.ADDR), 32'h00020);
        check("b2b second oe", 32'(bus1.OE), 32'h0);
        bus1.Req = 1'b0;
      end
      if (c == 7) check("b2b second data", 32'(bus1.Data_rd), 32'hCAFE);
    end
    check("b2b done count", 32'(dones), 32'd2);

    // Clamped instance: READ_WAIT=0 behaves as one wait cycle
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (bus2.Ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("clamp ready", 32'(ok), 32'h1);
    bus2.Req = 1'b1; bus2.Wr = 1'b0; bus2.Be = 2'b11; bus2.Addr_in = 20'h00007;
    @(negedge Clk);
    bus2.Req = 1'b0;
    check("clamp c1", 32'(st2), 32'(exp_st(0, 0, 1, 0, 0, 0, 0, 0)));
    @(negedge Clk);
    check("clamp c2", 32'(st2), 32'(exp_st(1, 1, 1, 1, 1, 0, 1, 0)));
    check("clamp data", 32'(bus2.Data_rd), 32'h7777);
    @(negedge Clk);
    check("clamp c3", 32'(st2), 32'(exp_st(1, 1, 1, 1, 1, 0, 0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Sequencer between the CPU memory interface (MAR/MDR load logic, ISDU memory states) and the external 1Mx16 async SRAM.
- Turns a single-cycle request/accept handshake into timed CE/OE/WE/UB/LB strobe sequences with parameterised wait states.
- Returns read data with a one-cycle Done pulse, so the state controller no longer hard-codes memory wait states.
- Sits directly downstream of the CPU memory port and upstream of the 16-bit tristate pad buffer.

Parameters:
- READ_WAIT, 2, cycles OE held low per read; values <1 clamp to 1.
- WRITE_WAIT, 2, cycles WE held low per write; values <1 clamp to 1.
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  1  access request; accepted on an edge where Req & Ready.
- Wr  in  1  1 = write, 0 = read; sampled with Req.
- Be  in  2  byte enables {upper, lower}; sampled with Req.
- Addr_in  in  ADDR_W  access address; sampled with Req.
- Data_wr  in  DATA_W  write data; sampled with Req.
- Ready  out  1  controller idle and able to accept.
- Done  out  1  one-cycle completion pulse.
- Data_rd  out  DATA_W  last captured read data.
- CE, OE, WE, UB, LB  out  1 each  SRAM strobes, active-low.
- ADDR  out  ADDR_W  SRAM address.
- Data_to_SRAM  out  DATA_W  write data to the tristate buffer.
- Data_from_SRAM  in  DATA_W  read data from the tristate buffer.
- Drive_en  out  1  tristate output enable, active-high.

Behaviour:
- Reset (Reset=0), asynchronous, takes effect immediately:
  - state IDLE; CE=OE=WE=UB=LB=1; Drive_en=0.
  - Ready=0, Done=0, Data_rd=0, ADDR=0, Data_to_SRAM=0.
  - First rising edge after release sets Ready=1.
  - Reset during any access aborts it: no Done, strobes go high the same instant.
- Ready=1 only in IDLE cycles.
- Accept edge (edge 0, Req&Ready): latches Addr_in, Wr, Be, Data_wr.
  - Later changes on these inputs are ignored until the next accept.
  - No queuing: Req while Ready=0 is ignored; the requester holds Req.
- States: IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- Read path:
  - RD_ACC for cycles 1..READ_WAIT: CE=0, OE=0, WE=1, UB=~Be[1], LB=~Be[0], ADDR=latched.
  - At the edge ending the last RD_ACC cycle, Data_from_SRAM is registered into Data_rd.
  - DONE at cycle READ_WAIT+1; IDLE at READ_WAIT+2.
- Write path:
  - WR_SETUP at cycle 1: CE=0, WE=1, Drive_en=1, byte strobes active.
  - WR_PULSE for cycles 2..WRITE_WAIT+1: WE=0.
  - WR_HOLD at cycle WRITE_WAIT+2: WE=1.
  - DONE at cycle WRITE_WAIT+3; IDLE at WRITE_WAIT+4.
  - OE=1 for the whole write.
  - Drive_en=1 and Data_to_SRAM=latched data from SETUP through HOLD.
- DONE state: all strobes high, Drive_en=0, Done=1 for exactly one cycle, Ready=0.
  - Req during DONE is not accepted.
- Data_rd holds its value until the next read capture; writes do not alter it.
- Be=00 is a legal access: full timing runs and Done pulses, but UB=LB=1 throughout.
- Drive_en and OE are never both active; assertion-checked.
- Wait counter:
  - loadable down-counter, width $clog2(max(READ_WAIT, WRITE_WAIT))+1;
  - loaded on accept (read) or on SETUP exit (write);
  - state advances when the count reaches 0.
- All outputs registered; no combinational path from Req to the strobes.

Decomposition:
- Package sram_access_pkg:
  - state enum typedef (IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, DONE);
  - strobe-idle constant (CE/OE/WE/UB/LB all 1);
  - clamp function for wait parameters.
- One sub-module, sram_wait_timer: loadable down-counter with zero flag, asynchronous active-low reset.

Test Plan:
- Reset sequence: assert Reset=0 mid-WR_PULSE -> WE/CE/OE=1, Drive_en=0, Ready=0 immediately, no Done. Release -> Ready=1 after the first edge.
- Read, READ_WAIT=2: Addr_in=0x00012, model returns 0xBEEF -> OE=CE=0 in cycles 1-2, Done=1 in cycle 3 with Data_rd=0xBEEF, Ready=1 in cycle 4.
- Write, WRITE_WAIT=2: Addr_in=0x0FFFF, Data_wr=0x1234, Be=11 -> CE=0 and Drive_en=1 in cycles 1-4, WE=0 in cycles 2-3, Data_to_SRAM=0x1234, Done in cycle 5, model memory[0x0FFFF]=0x1234.
- Byte write Be=10 with Data_wr=0xAB00 -> UB=0, LB=1 during access; model upper byte=0xAB, lower byte unchanged.
- Back-to-back: Req held high across two reads, Addr_in changed to 0x00020 during the first RD_ACC -> first read uses the latched address; second accepted only in IDLE (cycle 4); exactly two Done pulses.
- Clamp: READ_WAIT=0 instance -> OE low exactly 1 cycle, Done in cycle 2.
